// File: rtl/reg4_write_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter: state encodings
// and default sizing.
package reg4_write_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_IDW     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/reg4_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward from the
// pointer, wrapping at NUM_REQ-1.
module reg4_write_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     index,
    output logic               any
);

    always_comb begin
        int k;
        k      = 0;
        winner = '0;
        index  = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[IDW'(k)]) begin
                any                = 1'b1;
                winner[IDW'(k)]    = 1'b1;
                index              = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/reg4_write_arbiter.sv
// Round-robin arbiter sharing one register among NUM_REQ writers.
// Handshake: a writer holds Req and WrData until its one-cycle Ack; Req seen in IDLE is a new request.
module reg4_write_arbiter
    import reg4_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IDW     = DEF_IDW
) (
    input  logic                     Clock,
    input  logic                     ClearN,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] WrData,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Ack,
    output logic [WIDTH-1:0]         Q,
    output logic                     Busy,
    output logic [IDW-1:0]           LastId,
    output logic [1:0]               dbg_state
);

    arb_state_e           state, state_next;
    logic [IDW-1:0]       ptr, ptr_next;
    logic [IDW-1:0]       win_idx, win_next;
    logic [NUM_REQ-1:0]   grant_next, ack_next;
    logic [WIDTH-1:0]     q_next, win_data;
    logic [IDW-1:0]       last_next;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;

    reg4_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req    (Req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDW'(i)) win_data = WrData[i*WIDTH +: WIDTH];
        end
    end

    // Winner is frozen in win_idx for the GRANT cycle; new requests wait for IDLE.
    always_comb begin
        state_next = state;
        grant_next = '0;
        ack_next   = '0;
        q_next     = Q;
        last_next  = LastId;
        ptr_next   = ptr;
        win_next   = win_idx;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_GRANT;
                    grant_next = pick_onehot;
                    win_next   = pick_idx;
                end
            end
            ST_GRANT: begin
                if (Req[win_idx]) begin
                    state_next = ST_WRITE;
                    q_next     = win_data;
                    ack_next   = Grant;
                    last_next  = win_idx;
                    ptr_next   = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            win_idx <= '0;
            Grant   <= '0;
            Ack     <= '0;
            Q       <= '0;
            LastId  <= '0;
            Busy    <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            win_idx <= win_next;
            Grant   <= grant_next;
            Ack     <= ack_next;
            Q       <= q_next;
            LastId  <= last_next;
            Busy    <= (state_next != ST_IDLE);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Directed bench for reg4_write_arbiter; commits are checked by a queue-driven monitor.
module tb_reg4_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int IDW     = 2;

    logic                     Clock;
    logic                     ClearN;
    logic [NUM_REQ-1:0]       Req;
    logic [NUM_REQ*WIDTH-1:0] WrData;
    logic [NUM_REQ-1:0]       Grant;
    logic [NUM_REQ-1:0]       Ack;
    logic [WIDTH-1:0]         Q;
    logic                     Busy;
    logic [IDW-1:0]           LastId;
    logic [1:0]               dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [IDW+WIDTH-1:0] exp_q[$];

    reg4_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .Clock     (Clock),
        .ClearN    (ClearN),
        .Req       (Req),
        .WrData    (WrData),
        .Grant     (Grant),
        .Ack       (Ack),
        .Q         (Q),
        .Busy      (Busy),
        .LastId    (LastId),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every Ack must match the head of the expected queue
    always @(negedge Clock) begin
        if (ClearN && (Ack != '0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {28'd0, Ack}, 32'd0);
            end else begin
                logic [IDW+WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("ack_onehot", {28'd0, Ack}, 32'd1 << e[IDW+WIDTH-1:WIDTH]);
                check("ack_q", {28'd0, Q}, {28'd0, e[WIDTH-1:0]});
                check("ack_lastid", {30'd0, LastId}, {30'd0, e[IDW+WIDTH-1:WIDTH]});
            end
        end
        if (ClearN && ($countones(Grant) > 1))
            check("grant_onehot", {28'd0, Grant}, 32'd0);
    end

    // driver tasks
    task automatic expect_commit(input int id, input logic [WIDTH-1:0] d);
        exp_q.push_back({IDW'(id), d});
    endtask

    task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        WrData = {d3, d2, d1, d0};
    endtask

    // Drop each writer's Req once its Ack is seen; stop when all are idle.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            if (Ack != '0) Req = Req & ~Ack;
        end while ((Req != '0 || Busy) && n < budget);
        if (Req != '0 || Busy) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge Clock);
        Req    = '0;
        ClearN = 1'b0;
        @(negedge Clock);
        ClearN = 1'b1;
    endtask

    initial begin
        int acks, last_cyc, cyc;
        ClearN = 1'b0;
        Req    = '0;
        WrData = '0;
        #12;
        check("reset_q", {28'd0, Q}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_grant", {28'd0, Grant}, 32'd0);
        check("reset_lastid", {30'd0, LastId}, 32'd0);
        @(negedge Clock);
        ClearN = 1'b1;

        // load 4'hA via writer 1, then reset asynchronously during a GRANT
        set_data(4'h3, 4'hA, 4'h0, 4'h0);
        Req = 4'b0010;
        expect_commit(1, 4'hA);
        drain("load_a", 20);
        check("q_a", {28'd0, Q}, 32'hA);
        Req = 4'b0001;
        @(negedge Clock);
        check("pre_reset_grant", {28'd0, Grant}, 32'b0001);
        #2 ClearN = 1'b0;
        #1;
        check("async_q", {28'd0, Q}, 32'd0);
        check("async_busy", {31'd0, Busy}, 32'd0);
        check("async_grant", {28'd0, Grant}, 32'd0);
        check("async_state", {30'd0, dbg_state}, 32'd0);
        Req = '0;
        @(negedge Clock);
        ClearN = 1'b1;

        // single writer 2
        set_data(4'h0, 4'h0, 4'h5, 4'h0);
        Req = 4'b0100;
        expect_commit(2, 4'h5);
        @(negedge Clock);
        check("single_grant", {28'd0, Grant}, 32'b0100);
        check("single_busy1", {31'd0, Busy}, 32'd1);
        check("single_q_hold", {28'd0, Q}, 32'd0);
        @(negedge Clock);
        check("single_ack", {28'd0, Ack}, 32'b0100);
        check("single_grant_off", {28'd0, Grant}, 32'd0);
        Req = '0;
        @(negedge Clock);
        check("single_busy_fall", {31'd0, Busy}, 32'd0);
        check("single_ack_off", {28'd0, Ack}, 32'd0);
        check("single_lastid", {30'd0, LastId}, 32'd2);

        // wrap: pointer now 3, writers 0 and 3 -> 3 first, then 0
        set_data(4'h9, 4'h0, 4'h0, 4'hC);
        Req = 4'b1001;
        expect_commit(3, 4'hC);
        expect_commit(0, 4'h9);
        drain("wrap", 20);
        check("wrap_queue_empty", exp_q.size(), 32'd0);

        // fairness from pointer 0
        reset_pulse();
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        expect_commit(0, 4'h1);
        expect_commit(1, 4'h2);
        expect_commit(2, 4'h3);
        expect_commit(3, 4'h4);
        expect_commit(0, 4'h1);
        Req = 4'b1111;
        acks = 0; cyc = 0; last_cyc = 0;
        while (acks < 5 && cyc < 40) begin
            @(negedge Clock);
            cyc++;
            if (Ack != '0) begin
                if (acks > 0) check("fair_spacing", cyc - last_cyc, 32'd3);
                last_cyc = cyc;
                acks++;
            end
        end
        if (acks < 5) check("fair_timeout", acks, 32'd5);
        Req = '0;
        @(negedge Clock);
        @(negedge Clock);
        check("fair_q_final", {28'd0, Q}, 32'h1);

        // withdraw during GRANT: pointer is 1
        set_data(4'h6, 4'h7, 4'h0, 4'h0);
        Req = 4'b0010;
        @(negedge Clock);
        check("withdraw_grant", {28'd0, Grant}, 32'b0010);
        Req = '0;
        @(negedge Clock);
        check("withdraw_no_ack", {28'd0, Ack}, 32'd0);
        check("withdraw_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        check("withdraw_q", {28'd0, Q}, 32'h1);
        Req = 4'b0011;
        expect_commit(1, 4'h7);
        expect_commit(0, 4'h6);
        drain("withdraw_retry", 20);

        // reset during WRITE
        set_data(4'hE, 4'h0, 4'h8, 4'h0);
        Req = 4'b0100;
        expect_commit(2, 4'h8);
        @(negedge Clock);
        @(negedge Clock);
        check("wr_reset_ack_pre", {28'd0, Ack}, 32'b0100);
        #2 ClearN = 1'b0;
        #1;
        check("wr_reset_ack", {28'd0, Ack}, 32'd0);
        check("wr_reset_q", {28'd0, Q}, 32'd0);
        check("wr_reset_state", {30'd0, dbg_state}, 32'd0);
        Req = '0;
        @(negedge Clock);
        ClearN = 1'b1;
        Req = 4'b0101;
        expect_commit(0, 4'hE);
        expect_commit(2, 4'h8);
        drain("post_reset", 20);

        repeat (2) @(negedge Clock);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
